// File: rtl/reg_bank_pkg.sv
// Shared types and default sizing for the multi-port integer register bank.
package reg_bank_pkg;

  typedef enum logic {RB_INIT, RB_READY} rb_state_e;

  localparam int RB_XLEN  = 32;
  localparam int RB_NREGS = 32;
  localparam int RB_NRD   = 2;

  function automatic int rb_aw(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/reg_bank_rdport.sv
// One combinational read lane: array mux, same-cycle write bypass, zero-register and INIT forcing.
module reg_bank_rdport #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [NREGS-1:0][XLEN-1:0] regs,
  input  logic                       ready,
  input  logic [AW-1:0]              raddr,
  input  logic                       commit0,
  input  logic [AW-1:0]              waddr0,
  input  logic [XLEN-1:0]            wdata0,
  input  logic                       commit1,
  input  logic [AW-1:0]              waddr1,
  input  logic [XLEN-1:0]            wdata1,
  output logic [XLEN-1:0]            rdata
);

  always_comb begin
    rdata = regs[raddr];
    // Port 1 first so a port-0 hit on the same address overrides it.
    if (BYPASS != 0) begin
      if (commit1 && (waddr1 == raddr)) rdata = wdata1;
      if (commit0 && (waddr0 == raddr)) rdata = wdata0;
    end
    if (!ready || ((ZERO_REG != 0) && (raddr == '0))) rdata = '0;
  end

endmodule

// File: rtl/reg_bank_mp.sv
// Multi-port register bank: two prioritized write ports, NRD read lanes, sequenced clear after reset.
module reg_bank_mp
  import reg_bank_pkg::*;
#(
  parameter  int XLEN     = RB_XLEN,
  parameter  int NREGS    = RB_NREGS,
  parameter  int NRD      = RB_NRD,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = rb_aw(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  output logic                init_busy,
  input  logic                we0,
  input  logic [AW-1:0]       waddr0,
  input  logic [XLEN-1:0]     wdata0,
  input  logic                we1,
  input  logic [AW-1:0]       waddr1,
  input  logic [XLEN-1:0]     wdata1,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata
);

  localparam logic [AW:0] LAST = (AW+1)'(NREGS - 1);

  rb_state_e                  state_q, state_d;
  logic [AW:0]                cnt_q, cnt_d;
  logic [NREGS-1:0][XLEN-1:0] regs;
  logic                       ready, wr_ok, commit0, commit1;

  assign ready     = (state_q == RB_READY);
  assign init_busy = !ready;
  assign wr_ok     = ready && !clear;
  assign commit0   = wr_ok && we0 && !((ZERO_REG != 0) && (waddr0 == '0));
  // Port 1 loses any same-address collision with a committing port 0.
  assign commit1   = wr_ok && we1 && !((ZERO_REG != 0) && (waddr1 == '0))
                     && !(commit0 && (waddr1 == waddr0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RB_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RB_INIT: begin
        if (clear) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = RB_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RB_READY: begin
        if (clear) begin
          state_d = RB_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RB_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // No array reset: contents are zeroed one entry per cycle by the sequencer.
  always_ff @(posedge clk) begin
    if (!ready) begin
      regs[cnt_q[AW-1:0]] <= '0;
    end else begin
      if (commit1) regs[waddr1] <= wdata1;
      if (commit0) regs[waddr0] <= wdata0;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    reg_bank_rdport #(
      .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd (
      .regs   (regs),
      .ready  (ready),
      .raddr  (raddr[i*AW +: AW]),
      .commit0(commit0),
      .waddr0 (waddr0),
      .wdata0 (wdata0),
      .commit1(commit1),
      .waddr1 (waddr1),
      .wdata1 (wdata1),
      .rdata  (rdata[i*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Bench for reg_bank_mp: bypass and non-bypass banks share stimulus; a 16x64 three-lane bank runs alongside.
module tb_reg_bank_mp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared stimulus for the BYPASS=1 (a) and BYPASS=0 (b) instances.
  logic        clear, we0, we1, busy_a, busy_b;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic [9:0]  raddr;
  logic [63:0] rdata_a, rdata_b;

  // 16 entries, 64-bit, 3 lanes, no zero register.
  logic         clear_c, we0_c, we1_c, busy_c;
  logic [3:0]   wa0_c, wa1_c;
  logic [63:0]  wd0_c, wd1_c;
  logic [11:0]  raddr_c;
  logic [191:0] rdata_c;

  reg_bank_mp #(.BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .init_busy(busy_a),
    .we0(we0), .waddr0(wa0), .wdata0(wd0), .we1(we1), .waddr1(wa1), .wdata1(wd1),
    .raddr(raddr), .rdata(rdata_a));

  reg_bank_mp #(.BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .init_busy(busy_b),
    .we0(we0), .waddr0(wa0), .wdata0(wd0), .we1(we1), .waddr1(wa1), .wdata1(wd1),
    .raddr(raddr), .rdata(rdata_b));

  reg_bank_mp #(.XLEN(64), .NREGS(16), .NRD(3), .ZERO_REG(0)) dut_c (
    .clk(clk), .rst(rst), .clear(clear_c), .init_busy(busy_c),
    .we0(we0_c), .waddr0(wa0_c), .wdata0(wd0_c), .we1(we1_c), .waddr1(wa1_c), .wdata1(wd1_c),
    .raddr(raddr_c), .rdata(rdata_c));

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ea0, ea1, eb0, eb1;
  } row_t;

  typedef struct {
    int          id;
    logic [31:0] a0, a1, b0, b1;
  } exp_t;

  row_t rows [11];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear = 1'b0; we0 = 1'b0; we1 = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
  endtask

  // Counts edges from now until busy drops; 0 if it never drops within the budget.
  task automatic count_busy(input int start, output int fall_a, output int fall_b);
    fall_a = 0; fall_b = 0;
    for (int k = start; k <= 80; k++) begin
      tick();
      if (!busy_a && fall_a == 0) fall_a = k;
      if (!busy_b && fall_b == 0) fall_b = k;
      if (fall_a != 0 && fall_b != 0) break;
    end
  endtask

  initial begin
    int fa, fb, fc;
    exp_t e;

    rows[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,      5'd5,  5'd0,
                 32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    rows[1]  = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  32'h0,      5'd5,  5'd0,
                 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
    rows[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      5'd0,  5'd5,
                 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    rows[3]  = '{1'b1, 5'd7,  32'hAAAA0000, 1'b1, 5'd7,  32'h0000BBBB, 5'd7, 5'd7,
                 32'hAAAA0000, 32'hAAAA0000, 32'h0, 32'h0};
    rows[4]  = '{1'b1, 5'd8,  32'h0000CCCC, 1'b1, 5'd9,  32'h00009999, 5'd7, 5'd9,
                 32'hAAAA0000, 32'h00009999, 32'hAAAA0000, 32'h0};
    rows[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      5'd8,  5'd9,
                 32'h0000CCCC, 32'h00009999, 32'h0000CCCC, 32'h00009999};
    rows[6]  = '{1'b1, 5'd4,  32'h00000044, 1'b1, 5'd3,  32'h00000055, 5'd4, 5'd3,
                 32'h00000044, 32'h00000055, 32'h0, 32'h0};
    rows[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      5'd4,  5'd3,
                 32'h00000044, 32'h00000055, 32'h00000044, 32'h00000055};
    rows[8]  = '{1'b1, 5'd10, 32'h0000000A, 1'b1, 5'd0,  32'h0000FFFF, 5'd0, 5'd10,
                 32'h0, 32'h0000000A, 32'h0, 32'h0};
    rows[9]  = '{1'b1, 5'd0,  32'h00000077, 1'b1, 5'd11, 32'h0000000B, 5'd11, 5'd10,
                 32'h0000000B, 32'h0000000A, 32'h0, 32'h0000000A};
    rows[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      5'd11, 5'd7,
                 32'h0000000B, 32'hAAAA0000, 32'h0000000B, 32'hAAAA0000};

    rst = 1'b1;
    idle();
    raddr = {5'd3, 5'd5};
    clear_c = 1'b0; we0_c = 1'b0; we1_c = 1'b0;
    wa0_c = '0; wa1_c = '0; wd0_c = '0; wd1_c = '0;
    raddr_c = {4'd2, 4'd1, 4'd0};

    #3;
    check("rst_busy_a", 64'(busy_a), 64'd1);
    check("rst_rdata_a", rdata_a, 64'd0);
    check("rst_busy_c", 64'(busy_c), 64'd1);
    check("rst_rdata_c_lo", rdata_c[63:0], 64'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Count init length on both sizes at once.
    fa = 0; fc = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 5) check("init_rd_zero_a", rdata_a, 64'd0);
      if (!busy_a && fa == 0) fa = k;
      if (!busy_c && fc == 0) fc = k;
      if (fa != 0 && fc != 0) break;
    end
    check("init_len_a", 64'(fa), 64'd32);
    check("init_len_c", 64'(fc), 64'd16);

    for (int i = 0; i < 32; i++) begin
      raddr = {5'(31 - i), 5'(i)};
      @(negedge clk);
      check($sformatf("post_init_a0_%0d", i), rdata_a[31:0], 64'd0);
      check($sformatf("post_init_a1_%0d", i), rdata_a[63:32], 64'd0);
      check($sformatf("post_init_b0_%0d", i), rdata_b[31:0], 64'd0);
      tick();
    end

    // Table rows: expectations queued at drive time, popped mid-cycle.
    for (int r = 0; r < 11; r++) begin
      we0 = rows[r].we0; wa0 = rows[r].wa0; wd0 = rows[r].wd0;
      we1 = rows[r].we1; wa1 = rows[r].wa1; wd1 = rows[r].wd1;
      raddr = {rows[r].ra1, rows[r].ra0};
      sb.push_back('{r, rows[r].ea0, rows[r].ea1, rows[r].eb0, rows[r].eb1});
      @(negedge clk);
      if (sb.size() == 0) begin
        check("sb_underflow", 64'd0, 64'd1);
      end else begin
        e = sb.pop_front();
        check($sformatf("row%0d_a0", e.id), rdata_a[31:0],  64'(e.a0));
        check($sformatf("row%0d_a1", e.id), rdata_a[63:32], 64'(e.a1));
        check($sformatf("row%0d_b0", e.id), rdata_b[31:0],  64'(e.b0));
        check($sformatf("row%0d_b1", e.id), rdata_b[63:32], 64'(e.b1));
      end
      tick();
    end
    idle();

    // Fill x1..x31, then clear together with a write that must be dropped.
    for (int i = 1; i < 32; i++) begin
      we0 = 1'b1; wa0 = 5'(i); wd0 = 32'h1000_0000 + 32'(i);
      tick();
    end
    idle();
    raddr = {5'd31, 5'd9};
    @(negedge clk);
    check("fill_x9", rdata_a[31:0], 64'h10000009);
    check("fill_x31", rdata_b[63:32], 64'h1000001F);
    tick();

    clear = 1'b1; we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h00000BAD;
    @(negedge clk);
    check("clear_cycle_busy", 64'(busy_a), 64'd0);
    tick();
    idle();
    check("clear_next_busy", 64'(busy_a), 64'd1);
    count_busy(1, fa, fb);
    check("clear_len_a", 64'(fa), 64'd32);
    check("clear_len_b", 64'(fb), 64'd32);

    for (int i = 0; i < 32; i++) begin
      raddr = {5'(31 - i), 5'(i)};
      @(negedge clk);
      check($sformatf("post_clear_a0_%0d", i), rdata_a[31:0], 64'd0);
      check($sformatf("post_clear_b1_%0d", i), rdata_b[63:32], 64'd0);
      tick();
    end

    // Re-clear at INIT cycle 10: the count restarts from that edge.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("restart_busy", 64'(busy_a), 64'd1);
    count_busy(12, fa, fb);
    check("restart_len_a", 64'(fa), 64'd43);
    check("restart_len_b", 64'(fb), 64'd43);

    // 64-bit bank without zero register: x0 is writable and bypassed on every lane.
    raddr_c = {4'd0, 4'd0, 4'd0};
    we0_c = 1'b1; wa0_c = 4'd0; wd0_c = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    for (int l = 0; l < 3; l++)
      check($sformatf("c_byp_lane%0d", l), rdata_c[l*64 +: 64], 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    we0_c = 1'b0;
    @(negedge clk);
    for (int l = 0; l < 3; l++)
      check($sformatf("c_x0_lane%0d", l), rdata_c[l*64 +: 64], 64'hFFFF_FFFF_FFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
